// File: rtl/serial_segment_receiver.sv
// rtl/serial_segment_receiver.sv - oversampling receiver for the serial 7-segment display stream
// Reassembles one 8-bit segment frame per lane and decodes it back to a hex digit.
module serial_segment_receiver #(
  parameter int DIGITS       = 2,
  parameter int FRAME_BITS   = 8,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     seg_in,
  input  logic                  shift_in,
  input  logic                  shift_n_in,
  output logic [8*DIGITS-1:0]   seg_par,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     decode_err,
  output logic                  sync_err,
  output logic                  line_err
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [DIGITS-1:0]   r_seg_s1;
  logic [DIGITS-1:0]   r_seg_s2;
  logic                r_shift_s1;
  logic                r_shift_s2;
  logic                r_shift_s3;
  logic                r_shift_n_s1;
  logic                r_shift_n_s2;
  logic [7:0]          r_shreg [DIGITS];
  logic [2:0]          r_bit_cnt;
  logic [TW-1:0]       r_idle_cnt;
  logic [8*DIGITS-1:0] r_frame;
  logic                r_frame_done;
  logic                r_line_eq;
  logic [1:0]          r_fill;

  logic                w_edge;
  logic                w_line_eq;
  logic [7:0]          w_next_lane [DIGITS];
  logic [4:0]          w_dec [DIGITS];

  // Returns {err, value}; dp (bit0) takes no part in the match.
  function automatic logic [4:0] decode_seg(input logic [7:0] f);
    logic [4:0] r;
    case ({f[7:1], 1'b0})
      8'hFC:   r = 5'h00;
      8'h60:   r = 5'h01;
      8'hDA:   r = 5'h02;
      8'hF2:   r = 5'h03;
      8'h66:   r = 5'h04;
      8'hB6:   r = 5'h05;
      8'hBE:   r = 5'h06;
      8'hE0:   r = 5'h07;
      8'hFE:   r = 5'h08;
      8'hF6:   r = 5'h09;
      8'hEE:   r = 5'h0A;
      8'h3E:   r = 5'h0B;
      8'h9C:   r = 5'h0C;
      8'h7A:   r = 5'h0D;
      8'h9E:   r = 5'h0E;
      8'h8E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign w_edge    = r_shift_s2 & ~r_shift_s3;
  assign w_line_eq = (r_shift_s2 == r_shift_n_s2);

  always_comb begin
    for (int j = 0; j < DIGITS; j++) begin
      w_next_lane[j] = {r_shreg[j][6:0], r_seg_s2[j]};
      w_dec[j]       = decode_seg(r_frame[8*j +: 8]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_s1     <= '0;
      r_seg_s2     <= '0;
      r_shift_s1   <= 1'b0;
      r_shift_s2   <= 1'b0;
      r_shift_s3   <= 1'b0;
      r_shift_n_s1 <= 1'b0;
      r_shift_n_s2 <= 1'b0;
    end else begin
      r_seg_s1     <= seg_in;
      r_seg_s2     <= r_seg_s1;
      r_shift_s1   <= shift_in;
      r_shift_s2   <= r_shift_s1;
      r_shift_s3   <= r_shift_s2;
      r_shift_n_s1 <= shift_n_in;
      r_shift_n_s2 <= r_shift_n_s1;
    end
  end

  // Completed frames are staged one cycle in r_frame before reaching the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DIGITS; j++) r_shreg[j] <= '0;
      r_bit_cnt    <= '0;
      r_idle_cnt   <= '0;
      r_frame      <= '0;
      r_frame_done <= 1'b0;
      seg_par      <= '0;
      digit_val    <= '0;
      decode_err   <= '0;
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      sync_err     <= 1'b0;
      frame_valid  <= r_frame_done;
      if (r_frame_done) begin
        seg_par <= r_frame;
        for (int j = 0; j < DIGITS; j++) begin
          digit_val[4*j +: 4] <= w_dec[j][3:0];
          decode_err[j]       <= w_dec[j][4];
        end
      end
      if (w_edge) begin
        for (int j = 0; j < DIGITS; j++) r_shreg[j] <= w_next_lane[j];
        r_idle_cnt <= '0;
        if (r_bit_cnt == 3'(FRAME_BITS - 1)) begin
          r_bit_cnt    <= '0;
          r_frame_done <= 1'b1;
          for (int j = 0; j < DIGITS; j++) r_frame[8*j +: 8] <= w_next_lane[j];
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end else if (r_bit_cnt != 3'd0) begin
        if (r_idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
          r_idle_cnt <= '0;
          r_bit_cnt  <= '0;
          sync_err   <= 1'b1;
        end else begin
          r_idle_cnt <= r_idle_cnt + TW'(1);
        end
      end
    end
  end

  // r_fill masks the first cycles after reset, when both synchronizers still read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill    <= '0;
      r_line_eq <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      r_fill    <= {r_fill[0], 1'b1};
      r_line_eq <= w_line_eq & r_fill[1];
      if (r_fill[1] && r_line_eq && w_line_eq) line_err <= 1'b1;
    end
  end

endmodule
